// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter (fetch vs. load/store).
// Optional round-robin selection is enabled with MEM_ARB_ROUND_ROBIN_EN.
package mem_port_arbiter_pkg;

  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam int unsigned RISCV_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // The requester that is not the given one.
  function automatic arb_owner_e arb_other(input arb_owner_e own);
    return (own == ARB_OWN_D) ? ARB_OWN_I : ARB_OWN_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and LSU requests.
// MEM_ARB_ROUND_ROBIN_EN alternates on collisions; otherwise D beats I.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  arb_owner_e last_i,
  output arb_owner_e win_c_o
);

  always_comb begin
    win_c_o = ARB_OWN_I;
    if (d_req_i && !i_req_i) begin
      win_c_o = ARB_OWN_D;
    end else if (d_req_i && i_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_c_o = arb_other(last_i);
`else
      win_c_o = ARB_OWN_D;
`endif
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch (I) and LSU (D), one
// transaction in flight. MEM_ARB_ROUND_ROBIN_EN adds collision fairness.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = RISCV_DATA_WIDTH,
  localparam int unsigned BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic                  i_kill_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_err_o,
  input  logic                  d_req_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic                  d_we_i,
  input  logic [BE_W-1:0]       d_be_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [BE_W-1:0]       mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       kill_q, kill_d;
  logic       mem_req_q, mem_req_d;
  mem_cmd_t   cmd_q, cmd_d;
  arb_owner_e pick_last;
  arb_owner_e win_c;
  logic       done_c;
  logic       i_fire_c;
  logic       d_fire_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_e last_q, last_d;
  assign pick_last = last_q;
`else
  assign pick_last = ARB_OWN_I;
`endif

  mem_arb_pick u_pick (
    .i_req_i (i_req_i),
    .d_req_i (d_req_i),
    .last_i  (pick_last),
    .win_c_o (win_c)
  );

  // Next-state, command capture and same-cycle grant.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    kill_d    = kill_q;
    mem_req_d = mem_req_q;
    cmd_d     = cmd_q;
    done_c    = 1'b0;
    i_gnt_o   = 1'b0;
    d_gnt_o   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (i_req_i || d_req_i) begin
          owner_d   = win_c;
          state_d   = ARB_REQ;
          mem_req_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d    = win_c;
`endif
          if (win_c == ARB_OWN_D) begin
            cmd_d.addr  = d_addr_i;
            cmd_d.we    = d_we_i;
            cmd_d.be    = d_be_i;
            cmd_d.wdata = d_wdata_i;
            d_gnt_o     = 1'b1;
          end else begin
            cmd_d.addr  = i_addr_i;
            cmd_d.we    = 1'b0;
            cmd_d.be    = '1;
            cmd_d.wdata = '0;
            i_gnt_o     = 1'b1;
          end
        end
      end
      ARB_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (mem_rvalid_i) begin
            done_c  = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (mem_rvalid_i) begin
          done_c  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    // A redirect only poisons the fetch already on the bus.
    if (state_q != ARB_IDLE && owner_q == ARB_OWN_I && i_kill_i) begin
      kill_d = 1'b1;
    end
    if (done_c) begin
      kill_d = 1'b0;
    end
  end

  // Response routing to the current owner only.
  always_comb begin
    i_fire_c   = done_c && (owner_q == ARB_OWN_I) && !kill_q && !i_kill_i;
    d_fire_c   = done_c && (owner_q == ARB_OWN_D);
    i_rvalid_o = i_fire_c;
    i_rdata_o  = i_fire_c ? mem_rdata_i : '0;
    i_err_o    = i_fire_c & mem_err_i;
    d_rvalid_o = d_fire_c;
    d_rdata_o  = d_fire_c ? mem_rdata_i : '0;
    d_err_o    = d_fire_c & mem_err_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_OWN_I;
      kill_q    <= 1'b0;
      mem_req_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      kill_q    <= kill_d;
      mem_req_q <= mem_req_d;
      cmd_q     <= cmd_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ARB_OWN_I;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_we_o    = cmd_q.we;
  assign mem_be_o    = cmd_q.be;
  assign mem_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants,
// bus commands and responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req_i, i_kill_i, i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_be_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_kill_i(i_kill_i),
    .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wdata;
  } cmd_t;
  typedef struct {
    bit          own;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  bit   exp_gnt_q[$];
  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];
  rsp_t bus_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gnt_cyc[2];
  int rv_cyc[2];
  int gnt_wait = 0;
  int rv_wait  = 0;
  bit combined = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus responder: gnt after gnt_wait REQ cycles, rvalid rv_wait cycles later.
  initial begin
    int   phase;
    int   cnt;
    rsp_t b;
    phase = 0;
    cnt   = 0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
      if (!rst_n) begin
        phase = 0;
        cnt   = 0;
      end else if (phase == 0) begin
        if (mem_req_o) begin
          if (cnt >= gnt_wait) begin
            mem_gnt_i = 1'b1;
            cnt = 0;
            if (combined) begin
              if (bus_q.size() == 0) check("bus_underflow", 32'd1, 32'd0);
              else begin
                b = bus_q.pop_front();
                mem_rvalid_i = 1'b1; mem_rdata_i = b.rdata; mem_err_i = b.err;
              end
            end else begin
              phase = 1;
            end
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= rv_wait) begin
          if (bus_q.size() == 0) check("bus_underflow", 32'd1, 32'd0);
          else begin
            b = bus_q.pop_front();
            mem_rvalid_i = 1'b1; mem_rdata_i = b.rdata; mem_err_i = b.err;
          end
          phase = 0;
          cnt   = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant, bus handshake or response.
  always @(negedge clk) begin
    bit   g;
    cmd_t c;
    rsp_t r;
    if (rst_n) begin
      if (i_gnt_o || d_gnt_o) begin
        check("gnt_exclusive", 32'(i_gnt_o & d_gnt_o), 32'd0);
        if (d_gnt_o) gnt_cyc[1] = cyc; else gnt_cyc[0] = cyc;
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'd1, 32'd0);
        else begin
          g = exp_gnt_q.pop_front();
          check("gnt_owner", 32'(d_gnt_o), 32'(g));
        end
      end
      if (mem_req_o && mem_gnt_i) begin
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
        else begin
          c = exp_cmd_q.pop_front();
          check("cmd_addr", mem_addr_o, c.addr);
          check("cmd_we", 32'(mem_we_o), 32'(c.we));
          check("cmd_be", 32'(mem_be_o), 32'(c.be));
          if (c.chk_wdata) check("cmd_wdata", mem_wdata_o, c.wdata);
        end
      end
      if (i_rvalid_o || d_rvalid_o) begin
        check("rvalid_exclusive", 32'(i_rvalid_o & d_rvalid_o), 32'd0);
        if (d_rvalid_o) rv_cyc[1] = cyc; else rv_cyc[0] = cyc;
        if (exp_rsp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          r = exp_rsp_q.pop_front();
          check("rsp_owner", 32'(d_rvalid_o), 32'(r.own));
          check("rsp_rdata", d_rvalid_o ? d_rdata_o : i_rdata_o, r.rdata);
          check("rsp_err", 32'(d_rvalid_o ? d_err_o : i_err_o), 32'(r.err));
        end
      end
      if (!i_rvalid_o) check("i_quiet", {i_rdata_o[31:1], i_rdata_o[0] | i_err_o}, 32'd0);
      if (!d_rvalid_o) check("d_quiet", {d_rdata_o[31:1], d_rdata_o[0] | d_err_o}, 32'd0);
    end
  end

  task automatic expect_txn(input bit own, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic err, input bit visible);
    cmd_t c;
    rsp_t r;
    c.addr = addr; c.we = we; c.be = be; c.wdata = wdata; c.chk_wdata = own;
    r.own = own; r.rdata = rdata; r.err = err;
    exp_gnt_q.push_back(own);
    exp_cmd_q.push_back(c);
    bus_q.push_back(r);
    if (visible) exp_rsp_q.push_back(r);
  endtask

  task automatic issue_i(input logic [31:0] addr);
    int n;
    n = 0;
    @(posedge clk); #1;
    i_req_i = 1'b1; i_addr_i = addr;
    do begin @(negedge clk); n++; end while (!i_gnt_o && n < 200);
    check("i_gnt_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    i_req_i = 1'b0;
  endtask

  task automatic issue_d(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata);
    int n;
    n = 0;
    @(posedge clk); #1;
    d_req_i = 1'b1; d_addr_i = addr; d_we_i = we; d_be_i = be; d_wdata_i = wdata;
    do begin @(negedge clk); n++; end while (!d_gnt_o && n < 200);
    check("d_gnt_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    d_req_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_gnt_q.size() + exp_cmd_q.size() + exp_rsp_q.size() + bus_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain"}, 32'(n < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    i_req_i = 1'b0; i_addr_i = '0; i_kill_i = 1'b0;
    d_req_i = 1'b0; d_addr_i = '0; d_we_i = 1'b0; d_be_i = '0; d_wdata_i = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_be", 32'(mem_be_o), 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_gnts", 32'({i_gnt_o, d_gnt_o}), 32'd0);
    check("rst_rvalids", 32'({i_rvalid_o, d_rvalid_o, i_err_o, d_err_o}), 32'd0);
    check("rst_rdata", i_rdata_o | d_rdata_o, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Single fetch, gnt one cycle after mem_req_o.
    gnt_wait = 1; rv_wait = 0;
    expect_txn(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    issue_i(32'h100);
    wait_drain("single_fetch");

    // Collision: D write wins, I granted in the IDLE cycle after D's rvalid.
    gnt_wait = 0; rv_wait = 0;
    expect_txn(1'b1, 32'h2000, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b1);
    expect_txn(1'b0, 32'h104, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    fork
      issue_d(32'h2000, 1'b1, 4'hF, 32'h12345678);
      issue_i(32'h104);
    join
    wait_drain("collision1");
    check("d_zero_wait_cost", 32'(rv_cyc[1] - gnt_cyc[1]), 32'd2);
    check("i_after_d_rvalid", 32'(gnt_cyc[0] - rv_cyc[1]), 32'd1);

    // Second collision: D re-requests back to back while I waits.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expect_txn(1'b1, 32'h3000, 1'b0, 4'h1, 32'h0, 32'h00000031, 1'b0, 1'b1);
    expect_txn(1'b0, 32'h108, 1'b0, 4'hF, 32'h0, 32'h00000108, 1'b0, 1'b1);
    expect_txn(1'b1, 32'h3004, 1'b0, 4'h2, 32'h0, 32'h00000032, 1'b0, 1'b1);
`else
    expect_txn(1'b1, 32'h3000, 1'b0, 4'h1, 32'h0, 32'h00000031, 1'b0, 1'b1);
    expect_txn(1'b1, 32'h3004, 1'b0, 4'h2, 32'h0, 32'h00000032, 1'b0, 1'b1);
    expect_txn(1'b0, 32'h108, 1'b0, 4'hF, 32'h0, 32'h00000108, 1'b0, 1'b1);
`endif
    fork
      begin
        issue_d(32'h3000, 1'b0, 4'h1, 32'h0);
        issue_d(32'h3004, 1'b0, 4'h2, 32'h0);
      end
      issue_i(32'h108);
    join
    wait_drain("collision2");

    // Bus stall: five REQ cycles without gnt.
    gnt_wait = 5;
    expect_txn(1'b1, 32'h5000, 1'b1, 4'h3, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
    issue_d(32'h5000, 1'b1, 4'h3, 32'hA5A5A5A5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_req", 32'(mem_req_o), 32'd1);
      check("stall_addr", mem_addr_o, 32'h5000);
      check("stall_fields", 32'({mem_we_o, mem_be_o}), 32'h13);
      check("stall_wdata", mem_wdata_o, 32'hA5A5A5A5);
      check("stall_no_rvalid", 32'({i_rvalid_o, d_rvalid_o}), 32'd0);
    end
    wait_drain("stall");

    // Kill in RESP: response consumed silently, next fetch normal.
    gnt_wait = 0; rv_wait = 2;
    expect_txn(1'b0, 32'h200, 1'b0, 4'hF, 32'h0, 32'h22222222, 1'b0, 1'b0);
    issue_i(32'h200);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_gnt_i && n < 50);
    check("kill_gnt_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    i_kill_i = 1'b1;
    @(posedge clk); #1;
    i_kill_i = 1'b0;
    wait_drain("kill");
    rv_wait = 0;
    expect_txn(1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 32'h33333333, 1'b0, 1'b1);
    issue_i(32'h300);
    wait_drain("after_kill");

    // LSU load with bus error.
    expect_txn(1'b1, 32'h4, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b1, 1'b1);
    issue_d(32'h4, 1'b0, 4'hF, 32'h0);
    wait_drain("error");

    // gnt and rvalid together: two-cycle transaction.
    combined = 1'b1;
    expect_txn(1'b0, 32'h400, 1'b0, 4'hF, 32'h0, 32'h11112222, 1'b0, 1'b1);
    issue_i(32'h400);
    wait_drain("combined");
    check("combined_cost", 32'(rv_cyc[0] - gnt_cyc[0]), 32'd1);
    combined = 1'b0;

    // Reset while waiting in REQ.
    gnt_wait = 10;
    expect_txn(1'b0, 32'h500, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
    issue_i(32'h500);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("reset_async_req", 32'(mem_req_o), 32'd0);
    check("reset_async_addr", mem_addr_o, 32'd0);
    exp_gnt_q.delete(); exp_cmd_q.delete(); exp_rsp_q.delete(); bus_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    gnt_wait = 0;
    @(negedge clk);
    check("post_reset_idle_req", 32'(mem_req_o), 32'd0);
    expect_txn(1'b0, 32'h600, 1'b0, 4'hF, 32'h0, 32'h66666666, 1'b0, 1'b1);
    issue_i(32'h600);
    wait_drain("post_reset");

    check("queues_empty", 32'(exp_gnt_q.size() + exp_cmd_q.size() + exp_rsp_q.size() + bus_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
